// File: rtl/wt_dcache_rd_ctrl_pkg.sv
// Shared widths, request/response bundles and platform config
// for the write-through dcache read controller.
package wt_dcache_rd_ctrl_pkg;

    localparam int unsigned PLEN                = 56;
    localparam int unsigned DCACHE_SET_ASSOC    = 4;
    localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
    localparam int unsigned DCACHE_INDEX_WIDTH  = 12;
    localparam int unsigned DCACHE_CL_IDX_WIDTH = DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH;
    localparam int unsigned DCACHE_TAG_WIDTH    = PLEN - DCACHE_INDEX_WIDTH;
    localparam int unsigned CACHE_ID_WIDTH      = 3;
    localparam int unsigned NrCachedRegions     = 2;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic                          data_req;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [63:0] data_rdata;
    } dcache_req_o_t;

    typedef struct packed {
        logic [DCACHE_SET_ASSOC-1:0] vld;
        logic [63:0]                 data;
    } dcs_data_t;

    typedef struct packed {
        logic [NrCachedRegions-1:0][PLEN-1:0] cached_region_addr_base;
        logic [NrCachedRegions-1:0][PLEN-1:0] cached_region_length;
    } ariane_cfg_t;

    localparam ariane_cfg_t ArianeDefaultConfig = '{
        cached_region_addr_base: {56'h10_0000_0000, 56'h00_8000_0000},
        cached_region_length:    {56'h00_1000_0000, 56'h00_4000_0000}
    };

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MISS_REQ,
        MISS_WAIT,
        KILL_MISS,
        REPLAY,
        REPLAY_READ
    } rd_state_e;

    // One extra bit so base + length cannot wrap at the top of memory
    function automatic logic is_inside_cacheable_regions(
        ariane_cfg_t     cfg,
        logic [PLEN-1:0] addr
    );
        logic [PLEN:0] lo;
        logic [PLEN:0] hi;
        logic [PLEN:0] a;
        logic          hit;
        hit = 1'b0;
        a   = {1'b0, addr};
        for (int k = 0; k < NrCachedRegions; k++) begin
            lo  = {1'b0, cfg.cached_region_addr_base[k]};
            hi  = lo + {1'b0, cfg.cached_region_length[k]};
            hit = hit | ((a >= lo) && (a < hi));
        end
        return hit;
    endfunction

endpackage

// File: rtl/wt_dcache_rd_ctrl.sv
// Read-port controller for the write-through L1 dcache: arbitrates the
// array read port and sequences hits, misses, kills and replays.
module wt_dcache_rd_ctrl
    import wt_dcache_rd_ctrl_pkg::*;
#(
    parameter logic [CACHE_ID_WIDTH-1:0] RdTxId    = CACHE_ID_WIDTH'(1),
    parameter ariane_cfg_t               ArianeCfg = ArianeDefaultConfig
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           cache_en_i,
    input  dcache_req_i_t                  req_port_i,
    output dcache_req_o_t                  req_port_o,
    output logic                           miss_req_o,
    input  logic                           miss_ack_i,
    output logic                           miss_we_o,
    output logic [63:0]                    miss_wdata_o,
    output logic [DCACHE_SET_ASSOC-1:0]    miss_vld_bits_o,
    output logic [PLEN-1:0]                miss_paddr_o,
    output logic                           miss_nc_o,
    output logic [2:0]                     miss_size_o,
    output logic [CACHE_ID_WIDTH-1:0]      miss_id_o,
    output dcs_data_t                      miss_dcs_data_o,
    input  logic                           miss_replay_i,
    input  logic                           miss_rtrn_vld_i,
    input  logic                           wr_cl_vld_i,
    output logic [DCACHE_TAG_WIDTH-1:0]    rd_tag_o,
    output logic [DCACHE_CL_IDX_WIDTH-1:0] rd_idx_o,
    output logic [DCACHE_OFFSET_WIDTH-1:0] rd_off_o,
    output logic                           rd_req_o,
    output logic                           rd_tag_only_o,
    input  logic                           rd_ack_i,
    input  logic [63:0]                    rd_data_i,
    input  logic [DCACHE_SET_ASSOC-1:0]    rd_vld_bits_i,
    input  logic [DCACHE_SET_ASSOC-1:0]    rd_hit_oh_i
);

    rd_state_e                   state_q, state_d;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag_q, address_tag_d;
    logic [DCACHE_INDEX_WIDTH-1:0] address_idx_q, address_idx_d;
    logic [1:0]                    data_size_q, data_size_d;
    logic [DCACHE_SET_ASSOC-1:0]   vld_bits_q, vld_bits_d;
    logic                          rd_ack_q, rd_ack_d;

    logic                          gnt;
    logic                          rvalid;
    logic                          accept;
    logic [DCACHE_INDEX_WIDTH-1:0] cur_idx;

    assign cur_idx  = (state_q == IDLE) ? req_port_i.address_index : address_idx_q;
    assign rd_idx_o = cur_idx[DCACHE_INDEX_WIDTH-1:DCACHE_OFFSET_WIDTH];
    assign rd_off_o = cur_idx[DCACHE_OFFSET_WIDTH-1:0];
    assign rd_tag_o = req_port_i.tag_valid ? req_port_i.address_tag : address_tag_q;

    assign rd_tag_only_o   = 1'b0;
    assign miss_we_o       = 1'b0;
    assign miss_wdata_o    = '0;
    assign miss_dcs_data_o = '0;
    assign miss_id_o       = RdTxId;
    assign miss_vld_bits_o = vld_bits_q;
    assign miss_paddr_o    = {address_tag_q, address_idx_q};
    assign miss_nc_o       = ~cache_en_i
                           | ~is_inside_cacheable_regions(ArianeCfg, miss_paddr_o);
    assign miss_size_o     = miss_nc_o ? {1'b0, data_size_q} : 3'b111;

    assign req_port_o.data_gnt    = gnt;
    assign req_port_o.data_rvalid = rvalid;
    assign req_port_o.data_rdata  = rd_data_i;

    always_comb begin
        state_d       = state_q;
        address_tag_d = address_tag_q;
        address_idx_d = address_idx_q;
        data_size_d   = data_size_q;
        vld_bits_d    = vld_bits_q;
        rd_ack_d      = rd_ack_i;
        rd_req_o      = 1'b0;
        miss_req_o    = 1'b0;
        gnt           = 1'b0;
        rvalid        = 1'b0;
        accept        = 1'b0;

        unique case (state_q)
            IDLE: accept = 1'b1;
            READ, REPLAY_READ: begin
                rd_req_o = 1'b1;
                if (req_port_i.kill_req) begin
                    rvalid  = 1'b1;
                    state_d = IDLE;
                end else if (req_port_i.tag_valid || state_q == REPLAY_READ) begin
                    if (state_q == READ) begin
                        address_tag_d = req_port_i.address_tag;
                    end
                    // stale or clobbered array data must be read again
                    if (wr_cl_vld_i || !rd_ack_q) begin
                        state_d = REPLAY;
                    end else if (|rd_hit_oh_i && cache_en_i) begin
                        rvalid  = 1'b1;
                        state_d = IDLE;
                        accept  = 1'b1;
                    end else begin
                        vld_bits_d = rd_vld_bits_i;
                        state_d    = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                miss_req_o = 1'b1;
                if (req_port_i.kill_req) begin
                    rvalid  = 1'b1;
                    state_d = miss_ack_i ? KILL_MISS : IDLE;
                end else if (miss_replay_i) begin
                    state_d = REPLAY;
                end else if (miss_ack_i) begin
                    state_d = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (req_port_i.kill_req) begin
                    rvalid  = 1'b1;
                    state_d = miss_rtrn_vld_i ? IDLE : KILL_MISS;
                end else if (miss_rtrn_vld_i) begin
                    rvalid  = 1'b1;
                    state_d = IDLE;
                end
            end
            KILL_MISS: begin
                if (miss_rtrn_vld_i) begin
                    state_d = IDLE;
                end
            end
            REPLAY: begin
                rd_req_o = 1'b1;
                if (rd_ack_i) begin
                    state_d = REPLAY_READ;
                end
            end
            default: state_d = IDLE;
        endcase

        // a hit retiring in READ may accept the next request in the same cycle
        if (accept && req_port_i.data_req) begin
            rd_req_o = 1'b1;
            if (rd_ack_i) begin
                gnt           = 1'b1;
                address_idx_d = req_port_i.address_index;
                data_size_d   = req_port_i.data_size;
                state_d       = READ;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            address_tag_q <= '0;
            address_idx_q <= '0;
            data_size_q   <= '0;
            vld_bits_q    <= '0;
            rd_ack_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            address_tag_q <= address_tag_d;
            address_idx_q <= address_idx_d;
            data_size_q   <= data_size_d;
            vld_bits_q    <= vld_bits_d;
            rd_ack_q      <= rd_ack_d;
        end
    end

endmodule

// File: tb/tb_wt_dcache_rd_ctrl.sv
// Randomized bench for wt_dcache_rd_ctrl: the bench plays core, array
// and miss unit, and predicts each transaction from the protocol rules.
module tb_wt_dcache_rd_ctrl;
    import wt_dcache_rd_ctrl_pkg::*;

    localparam logic [CACHE_ID_WIDTH-1:0] TX_ID = 3'd5;
    localparam longint unsigned R0_BASE = 64'h00_8000_0000;
    localparam longint unsigned R0_LEN  = 64'h00_4000_0000;
    localparam longint unsigned R1_BASE = 64'h10_0000_0000;
    localparam longint unsigned R1_LEN  = 64'h00_1000_0000;

    logic                           clk;
    logic                           rst_n;
    logic                           cache_en;
    dcache_req_i_t                  req;
    dcache_req_o_t                  rsp;
    logic                           miss_req;
    logic                           miss_ack;
    logic                           miss_we;
    logic [63:0]                    miss_wdata;
    logic [DCACHE_SET_ASSOC-1:0]    miss_vld;
    logic [PLEN-1:0]                miss_paddr;
    logic                           miss_nc;
    logic [2:0]                     miss_size;
    logic [CACHE_ID_WIDTH-1:0]      miss_id;
    dcs_data_t                      miss_dcs;
    logic                           miss_replay;
    logic                           rtrn;
    logic                           wr_cl;
    logic [DCACHE_TAG_WIDTH-1:0]    rd_tag;
    logic [DCACHE_CL_IDX_WIDTH-1:0] rd_idx;
    logic [DCACHE_OFFSET_WIDTH-1:0] rd_off;
    logic                           rd_req;
    logic                           rd_tag_only;
    logic                           rd_ack;
    logic [63:0]                    rd_data;
    logic [DCACHE_SET_ASSOC-1:0]    vld_bits;
    logic [DCACHE_SET_ASSOC-1:0]    hit_oh;

    int vectors = 0;
    int errors  = 0;

    wt_dcache_rd_ctrl #(.RdTxId(TX_ID)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .cache_en_i      (cache_en),
        .req_port_i      (req),
        .req_port_o      (rsp),
        .miss_req_o      (miss_req),
        .miss_ack_i      (miss_ack),
        .miss_we_o       (miss_we),
        .miss_wdata_o    (miss_wdata),
        .miss_vld_bits_o (miss_vld),
        .miss_paddr_o    (miss_paddr),
        .miss_nc_o       (miss_nc),
        .miss_size_o     (miss_size),
        .miss_id_o       (miss_id),
        .miss_dcs_data_o (miss_dcs),
        .miss_replay_i   (miss_replay),
        .miss_rtrn_vld_i (rtrn),
        .wr_cl_vld_i     (wr_cl),
        .rd_tag_o        (rd_tag),
        .rd_idx_o        (rd_idx),
        .rd_off_o        (rd_off),
        .rd_req_o        (rd_req),
        .rd_tag_only_o   (rd_tag_only),
        .rd_ack_i        (rd_ack),
        .rd_data_i       (rd_data),
        .rd_vld_bits_i   (vld_bits),
        .rd_hit_oh_i     (hit_oh)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // reference: an access is non-cacheable when the cache is off or it
    // falls outside every [base, base+len) window of the platform map
    function automatic bit exp_nc(bit en, logic [PLEN-1:0] pa);
        longint unsigned a;
        bit              in_map;
        a      = 64'(pa);
        in_map = (a >= R0_BASE && a < R0_BASE + R0_LEN)
              || (a >= R1_BASE && a < R1_BASE + R1_LEN);
        return !en || !in_map;
    endfunction

    function automatic logic [PLEN-1:0] rand_paddr(int kind);
        longint unsigned a;
        case (kind)
            0: a = R0_BASE + 64'($urandom_range(0, 32'h3fff_ffff));
            1: a = R1_BASE + 64'($urandom_range(0, 32'h0fff_ffff));
            2: a = 64'($urandom_range(0, 32'h7fff_ffff));
            3: a = 64'h20_0000_0000 + 64'($urandom);
            4: a = R0_BASE + R0_LEN;
            5: a = R0_BASE + R0_LEN - 1;
            6: a = R0_BASE - 1;
            default: a = R0_BASE;
        endcase
        return a[PLEN-1:0];
    endfunction

    task automatic clear_in();
        req         = '0;
        miss_ack    = 1'b0;
        miss_replay = 1'b0;
        rtrn        = 1'b0;
        wr_cl       = 1'b0;
        rd_ack      = 1'b0;
        rd_data     = '0;
        vld_bits    = '0;
        hit_oh      = '0;
    endtask

    task automatic do_grant(input logic [11:0] idx, input logic [1:0] sz);
        clear_in();
        req.data_req      = 1'b1;
        req.address_index = idx;
        req.data_size     = sz;
        rd_ack            = 1'b1;
        #1;
        vectors++;
        if (rsp.data_gnt !== 1'b1 || rd_req !== 1'b1
            || rd_idx !== idx[11:4] || rd_off !== idx[3:0]) begin
            errors++;
            $display("FAIL grant: gnt=%b rd_req=%b idx=%h off=%h, want 1 1 %h %h",
                     rsp.data_gnt, rd_req, rd_idx, rd_off, idx[11:4], idx[3:0]);
        end
        @(negedge clk);
    endtask

    task automatic idle_probe(input string name);
        clear_in();
        req.data_req = 1'b1;
        #1;
        vectors++;
        if (rd_req !== 1'b1 || rsp.data_rvalid !== 1'b0 || rsp.data_gnt !== 1'b0
            || miss_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: rd_req=%b rvalid=%b gnt=%b miss_req=%b, want 1 0 0 0",
                     name, rd_req, rsp.data_rvalid, rsp.data_gnt, miss_req);
        end
        @(negedge clk);
        clear_in();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        cache_en = 1'b1;
        clear_in();
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (rsp.data_gnt !== 1'b0 || rsp.data_rvalid !== 1'b0
            || rd_req !== 1'b0 || miss_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: gnt=%b rvalid=%b rd_req=%b miss_req=%b, want 0",
                     rsp.data_gnt, rsp.data_rvalid, rd_req, miss_req);
        end
        vectors++;
        if (miss_paddr !== '0 || miss_vld !== '0 || rd_tag !== '0
            || miss_nc !== 1'b1 || miss_size !== 3'b000) begin
            errors++;
            $display("FAIL reset_regs: paddr=%h vld=%b tag=%h nc=%b size=%b, want 0 0 0 1 000",
                     miss_paddr, miss_vld, rd_tag, miss_nc, miss_size);
        end
        vectors++;
        if (miss_id !== TX_ID || miss_we !== 1'b0 || miss_wdata !== '0
            || miss_dcs !== '0 || rd_tag_only !== 1'b0) begin
            errors++;
            $display("FAIL reset_const: id=%h we=%b wdata=%h tag_only=%b, want %h 0 0 0",
                     miss_id, miss_we, miss_wdata, rd_tag_only, TX_ID);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_hit(input int n);
        logic [11:0]                 idx;
        logic [DCACHE_TAG_WIDTH-1:0] tag;
        logic [63:0]                 d;
        logic [3:0]                  oh;
        for (int it = 0; it < n; it++) begin
            idx = (it == 0) ? 12'h040 : 12'($urandom);
            tag = DCACHE_TAG_WIDTH'({$urandom, $urandom});
            d   = (it == 0) ? 64'hDEADBEEF : {$urandom, $urandom};
            oh  = (it == 0) ? 4'b0001 : 4'(1) << $urandom_range(0, 3);
            do_grant(idx, 2'($urandom));
            clear_in();
            req.tag_valid     = 1'b1;
            req.address_tag   = tag;
            req.address_index = 12'($urandom);
            hit_oh            = oh;
            rd_data           = d;
            vld_bits          = 4'($urandom);
            #1;
            vectors++;
            if (rsp.data_rvalid !== 1'b1 || rsp.data_rdata !== d || miss_req !== 1'b0) begin
                errors++;
                $display("FAIL hit_data: rvalid=%b data=%h miss_req=%b, want 1 %h 0",
                         rsp.data_rvalid, rsp.data_rdata, miss_req, d);
            end
            vectors++;
            if (rd_tag !== tag || rd_idx !== idx[11:4] || rd_req !== 1'b1) begin
                errors++;
                $display("FAIL hit_addr: tag=%h idx=%h rd_req=%b, want %h %h 1",
                         rd_tag, rd_idx, rd_req, tag, idx[11:4]);
            end
            @(negedge clk);
            idle_probe("hit");
        end
    endtask

    task automatic test_back_to_back(input int n);
        logic [11:0]                 ia, ib;
        logic [DCACHE_TAG_WIDTH-1:0] ta, tb;
        logic [63:0]                 da, db;
        for (int it = 0; it < n; it++) begin
            ia = 12'($urandom);
            ib = 12'($urandom);
            ta = DCACHE_TAG_WIDTH'({$urandom, $urandom});
            tb = DCACHE_TAG_WIDTH'({$urandom, $urandom});
            da = {$urandom, $urandom};
            db = {$urandom, $urandom};
            do_grant(ia, 2'($urandom));
            clear_in();
            req.tag_valid     = 1'b1;
            req.address_tag   = ta;
            hit_oh            = 4'(1) << $urandom_range(0, 3);
            rd_data           = da;
            req.data_req      = 1'b1;
            req.address_index = ib;
            rd_ack            = 1'b1;
            #1;
            vectors++;
            if (rsp.data_rvalid !== 1'b1 || rsp.data_rdata !== da || rsp.data_gnt !== 1'b1) begin
                errors++;
                $display("FAIL b2b_first: rvalid=%b data=%h gnt=%b, want 1 %h 1",
                         rsp.data_rvalid, rsp.data_rdata, rsp.data_gnt, da);
            end
            @(negedge clk);
            clear_in();
            req.tag_valid   = 1'b1;
            req.address_tag = tb;
            hit_oh          = 4'(1) << $urandom_range(0, 3);
            rd_data         = db;
            #1;
            vectors++;
            if (rsp.data_rvalid !== 1'b1 || rsp.data_rdata !== db || rsp.data_gnt !== 1'b0
                || rd_idx !== ib[11:4] || rd_off !== ib[3:0]) begin
                errors++;
                $display("FAIL b2b_second: rvalid=%b data=%h gnt=%b idx=%h, want 1 %h 0 %h",
                         rsp.data_rvalid, rsp.data_rdata, rsp.data_gnt, rd_idx, db, ib[11:4]);
            end
            @(negedge clk);
            idle_probe("b2b");
        end
    endtask

    task automatic test_miss(input int n);
        logic [PLEN-1:0] pa;
        logic [1:0]      sz;
        logic [3:0]      vb;
        logic [63:0]     d;
        logic [2:0]      esz;
        bit              en, nc;
        int              w;
        for (int it = 0; it < n; it++) begin
            pa  = rand_paddr($urandom_range(0, 7));
            en  = ($urandom_range(0, 3) != 0);
            sz  = 2'($urandom);
            vb  = 4'($urandom);
            d   = (it == 0) ? 64'h1234 : {$urandom, $urandom};
            nc  = exp_nc(en, pa);
            esz = nc ? {1'b0, sz} : 3'b111;
            cache_en = en;
            do_grant(pa[11:0], sz);
            clear_in();
            req.tag_valid   = 1'b1;
            req.address_tag = pa[PLEN-1:12];
            vld_bits        = vb;
            hit_oh          = en ? 4'b0000 : 4'(1) << $urandom_range(0, 3);
            #1;
            vectors++;
            if (rsp.data_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL miss_cmp: rvalid=%b, want 0", rsp.data_rvalid);
            end
            @(negedge clk);
            w = int'($urandom_range(0, 2));
            for (int i = 0; i <= w; i++) begin
                clear_in();
                miss_ack = (i == w);
                vld_bits = 4'($urandom);
                #1;
                vectors++;
                if (miss_req !== 1'b1 || rsp.data_rvalid !== 1'b0 || rd_req !== 1'b0) begin
                    errors++;
                    $display("FAIL miss_req: miss_req=%b rvalid=%b rd_req=%b, want 1 0 0",
                             miss_req, rsp.data_rvalid, rd_req);
                end
                vectors++;
                if (miss_paddr !== pa || miss_nc !== nc || miss_size !== esz
                    || miss_id !== TX_ID || miss_vld !== vb || miss_we !== 1'b0) begin
                    errors++;
                    $display("FAIL miss_fields: pa=%h nc=%b sz=%b id=%h vld=%b, want %h %b %b %h %b",
                             miss_paddr, miss_nc, miss_size, miss_id, miss_vld,
                             pa, nc, esz, TX_ID, vb);
                end
                @(negedge clk);
            end
            w = int'($urandom_range(0, 2));
            for (int i = 0; i <= w; i++) begin
                clear_in();
                rtrn    = (i == w);
                rd_data = d;
                #1;
                vectors++;
                if (rsp.data_rvalid !== rtrn || miss_req !== 1'b0
                    || (rtrn && rsp.data_rdata !== d)) begin
                    errors++;
                    $display("FAIL miss_rtrn: rvalid=%b data=%h miss_req=%b, want %b %h 0",
                             rsp.data_rvalid, rsp.data_rdata, miss_req, rtrn, d);
                end
                @(negedge clk);
            end
            idle_probe("miss");
        end
        cache_en = 1'b1;
    endtask

    task automatic test_kill(input int n);
        logic [PLEN-1:0] pa;
        int              p;
        bit              drain;
        for (int it = 0; it < n; it++) begin
            p     = (it < 5) ? it : int'($urandom_range(0, 4));
            pa    = rand_paddr(2);
            drain = 1'b0;
            do_grant(pa[11:0], 2'($urandom));
            clear_in();
            if (p == 0) begin
                req.kill_req = 1'b1;
                #1;
                vectors++;
                if (rsp.data_rvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL kill_read: rvalid=%b, want 1", rsp.data_rvalid);
                end
                @(negedge clk);
            end else begin
                req.tag_valid   = 1'b1;
                req.address_tag = pa[PLEN-1:12];
                #1;
                @(negedge clk);
                clear_in();
                if (p <= 2) begin
                    req.kill_req = 1'b1;
                    miss_ack     = (p == 2);
                    #1;
                    vectors++;
                    if (rsp.data_rvalid !== 1'b1 || miss_req !== 1'b1) begin
                        errors++;
                        $display("FAIL kill_missreq: rvalid=%b miss_req=%b, want 1 1",
                                 rsp.data_rvalid, miss_req);
                    end
                    drain = (p == 2);
                end else begin
                    miss_ack = 1'b1;
                    #1;
                    @(negedge clk);
                    clear_in();
                    req.kill_req = 1'b1;
                    rtrn         = (p == 4);
                    #1;
                    vectors++;
                    if (rsp.data_rvalid !== 1'b1) begin
                        errors++;
                        $display("FAIL kill_misswait: rvalid=%b, want 1", rsp.data_rvalid);
                    end
                    drain = (p == 3);
                end
                @(negedge clk);
            end
            if (drain) begin
                repeat ($urandom_range(1, 3)) begin
                    clear_in();
                    req.data_req = 1'b1;
                    rd_ack       = 1'b1;
                    #1;
                    vectors++;
                    if (rsp.data_rvalid !== 1'b0 || rd_req !== 1'b0
                        || rsp.data_gnt !== 1'b0 || miss_req !== 1'b0) begin
                        errors++;
                        $display("FAIL kill_drain: rvalid=%b rd_req=%b gnt=%b miss_req=%b, want 0",
                                 rsp.data_rvalid, rd_req, rsp.data_gnt, miss_req);
                    end
                    @(negedge clk);
                end
                clear_in();
                rtrn    = 1'b1;
                rd_data = {$urandom, $urandom};
                #1;
                vectors++;
                if (rsp.data_rvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL kill_rtrn: rvalid=%b, want 0", rsp.data_rvalid);
                end
                @(negedge clk);
            end
            idle_probe("kill");
        end
    endtask

    task automatic test_collision(input int n);
        logic [11:0]                 idx;
        logic [DCACHE_TAG_WIDTH-1:0] tag;
        logic [63:0]                 d;
        logic [3:0]                  oh;
        int                          v, w;
        for (int it = 0; it < n; it++) begin
            v   = (it < 3) ? it : int'($urandom_range(0, 2));
            idx = 12'($urandom);
            tag = DCACHE_TAG_WIDTH'({$urandom, $urandom});
            d   = {$urandom, $urandom};
            oh  = 4'(1) << $urandom_range(0, 3);
            do_grant(idx, 2'($urandom));
            clear_in();
            if (v == 1) begin
                #1;
                vectors++;
                if (rsp.data_rvalid !== 1'b0 || rd_req !== 1'b1) begin
                    errors++;
                    $display("FAIL coll_wait: rvalid=%b rd_req=%b, want 0 1",
                             rsp.data_rvalid, rd_req);
                end
                @(negedge clk);
                clear_in();
            end
            req.tag_valid   = 1'b1;
            req.address_tag = tag;
            wr_cl           = (v == 0);
            hit_oh          = (v == 2) ? 4'b0000 : oh;
            rd_data         = d;
            #1;
            vectors++;
            if (rsp.data_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL coll_cmp: rvalid=%b, want 0 (variant %0d)", rsp.data_rvalid, v);
            end
            @(negedge clk);
            if (v == 2) begin
                clear_in();
                miss_replay = 1'b1;
                #1;
                vectors++;
                if (miss_req !== 1'b1 || rsp.data_rvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL coll_missrep: miss_req=%b rvalid=%b, want 1 0",
                             miss_req, rsp.data_rvalid);
                end
                @(negedge clk);
            end
            w = int'($urandom_range(0, 2));
            for (int i = 0; i <= w; i++) begin
                clear_in();
                rd_ack = (i == w);
                #1;
                vectors++;
                if (rd_req !== 1'b1 || rd_idx !== idx[11:4] || rd_tag !== tag
                    || rsp.data_rvalid !== 1'b0 || miss_req !== 1'b0) begin
                    errors++;
                    $display("FAIL coll_replay: rd_req=%b idx=%h tag=%h rvalid=%b, want 1 %h %h 0",
                             rd_req, rd_idx, rd_tag, rsp.data_rvalid, idx[11:4], tag);
                end
                @(negedge clk);
            end
            clear_in();
            hit_oh  = oh;
            rd_data = d;
            #1;
            vectors++;
            if (rsp.data_rvalid !== 1'b1 || rsp.data_rdata !== d
                || rd_tag !== tag || rd_req !== 1'b1) begin
                errors++;
                $display("FAIL coll_reread: rvalid=%b data=%h tag=%h, want 1 %h %h",
                         rsp.data_rvalid, rsp.data_rdata, rd_tag, d, tag);
            end
            @(negedge clk);
            idle_probe("coll");
        end
    endtask

    task automatic test_reset_mid();
        logic [PLEN-1:0] pa;
        pa = rand_paddr(0);
        do_grant(pa[11:0], 2'd3);
        clear_in();
        req.tag_valid   = 1'b1;
        req.address_tag = pa[PLEN-1:12];
        #1;
        @(negedge clk);
        clear_in();
        #1;
        vectors++;
        if (miss_req !== 1'b1 || miss_paddr !== pa) begin
            errors++;
            $display("FAIL rstmid_pre: miss_req=%b pa=%h, want 1 %h", miss_req, miss_paddr, pa);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (miss_req !== 1'b0 || miss_paddr !== '0 || rd_req !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: miss_req=%b pa=%h rd_req=%b, want 0 0 0",
                     miss_req, miss_paddr, rd_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle_probe("rstmid");
    endtask

    initial begin
        rst_n    = 1'b0;
        cache_en = 1'b1;
        clear_in();
        test_reset();
        test_hit(20);
        test_back_to_back(10);
        test_miss(30);
        test_kill(25);
        test_collision(20);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
